// File: rtl/condlogic_pkg.sv
// Shared types and constants for the conditional-execution block.
// Holds ARM condition codes, flag bit positions and the FSM state type.
package condlogic_pkg;

   localparam logic [3:0] EQ = 4'b0000;
   localparam logic [3:0] NE = 4'b0001;
   localparam logic [3:0] CS = 4'b0010;
   localparam logic [3:0] CC = 4'b0011;
   localparam logic [3:0] MI = 4'b0100;
   localparam logic [3:0] PL = 4'b0101;
   localparam logic [3:0] VS = 4'b0110;
   localparam logic [3:0] VC = 4'b0111;
   localparam logic [3:0] HI = 4'b1000;
   localparam logic [3:0] LS = 4'b1001;
   localparam logic [3:0] GE = 4'b1010;
   localparam logic [3:0] LT = 4'b1011;
   localparam logic [3:0] GT = 4'b1100;
   localparam logic [3:0] LE = 4'b1101;
   localparam logic [3:0] AL = 4'b1110;
   localparam logic [3:0] NV = 4'b1111;

   localparam int FN = 3;
   localparam int FZ = 2;
   localparam int FC = 1;
   localparam int FV = 0;

   typedef enum logic {IDLE, BLOCK} state_t;

endpackage

// File: rtl/condlogic_if.sv
// Bundle of decoder requests and qualified write enables.
// master drives Cond/flags/requests/IT fields; slave drives enables, Flags, InBlock.
interface condlogic_if #(
   parameter int MAXBLK = 4
);
   localparam int LW = $clog2(MAXBLK + 1);

   logic [3:0]        Cond;
   logic [3:0]        ALUFlags;
   logic [1:0]        FlagW;
   logic              PCS;
   logic              NextPC;
   logic              RegW;
   logic              MemW;
   logic              NoWrite;
   logic              DecodeEn;
   logic              ItStart;
   logic [3:0]        ItCond;
   logic [MAXBLK-1:0] ItMask;
   logic [LW-1:0]     ItLen;
   logic              PCWrite;
   logic              RegWrite;
   logic              MemWrite;
   logic              CondExD;
   logic [3:0]        Flags;
   logic              InBlock;

   modport master (
      output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, NoWrite,
      output DecodeEn, ItStart, ItCond, ItMask, ItLen,
      input  PCWrite, RegWrite, MemWrite, CondExD, Flags, InBlock
   );

   modport slave (
      input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, NoWrite,
      input  DecodeEn, ItStart, ItCond, ItMask, ItLen,
      output PCWrite, RegWrite, MemWrite, CondExD, Flags, InBlock
   );

endinterface

// File: rtl/condlogic_mc_condcheck.sv
// ARM condition evaluation: Cond, Flags {N,Z,C,V} -> CondEx.
// Purely combinational; NV (1111) never executes.
module condcheck
   import condlogic_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v, ge;

   always_comb begin
      n  = Flags[FN];
      z  = Flags[FZ];
      c  = Flags[FC];
      v  = Flags[FV];
      ge = (n == v);
      case (Cond)
         EQ:      CondEx = z;
         NE:      CondEx = ~z;
         CS:      CondEx = c;
         CC:      CondEx = ~c;
         MI:      CondEx = n;
         PL:      CondEx = ~n;
         VS:      CondEx = v;
         VC:      CondEx = ~v;
         HI:      CondEx = c & ~z;
         LS:      CondEx = ~c | z;
         GE:      CondEx = ge;
         LT:      CondEx = ~ge;
         GT:      CondEx = ~z & ge;
         LE:      CondEx = z | ~ge;
         AL:      CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/condlogic_mc.sv
// Multi-cycle conditional logic with predicate (IT-style) blocks.
// Ports: clk, reset (async high), bus (condlogic_if.slave).
module condlogic_mc
   import condlogic_pkg::*;
#(
   parameter int MAXBLK = 4,
   parameter bit IT_EN  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   condlogic_if.slave  bus
);

   localparam int LW = $clog2(MAXBLK + 1);

   state_t            state;
   logic [LW-1:0]     rem;
   logic [LW-1:0]     idx;
   logic [MAXBLK-1:0] mask_l;
   logic [3:0]        cond_l;
   logic [3:0]        flags;
   logic              condexd;
   logic              condex;
   logic              mbit;
   logic              opener;
   logic [3:0]        eff;
   logic [LW-1:0]     len_c;
   logic [1:0]        flagwrite;

   // Mask bit for the current slot; idx may exceed range only once idle.
   always_comb begin
      mbit = 1'b0;
      for (int i = 0; i < MAXBLK; i++) begin
         if (idx == LW'(i)) mbit = mask_l[i];
      end
   end

   // Inverse condition flips bit 0, except AL which must stay AL.
   always_comb begin
      eff = bus.Cond;
      if (state == BLOCK) begin
         if (mbit)              eff = cond_l;
         else if (cond_l == AL) eff = AL;
         else                   eff = {cond_l[3:1], ~cond_l[0]};
      end
   end

   condcheck u_cc (
      .Cond   (eff),
      .Flags  (flags),
      .CondEx (condex)
   );

   // Only an instruction decoded in IDLE can open a block.
   assign opener = IT_EN && bus.DecodeEn && bus.ItStart
                   && (state == IDLE);
   assign len_c  = (bus.ItLen > LW'(MAXBLK)) ? LW'(MAXBLK) : bus.ItLen;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rem    <= '0;
         idx    <= '0;
         mask_l <= '0;
         cond_l <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (opener && (bus.ItLen != '0)) begin
                  state  <= BLOCK;
                  rem    <= len_c;
                  idx    <= '0;
                  mask_l <= bus.ItMask;
                  cond_l <= bus.ItCond;
               end
            end
            BLOCK: begin
               if (bus.DecodeEn) begin
                  idx <= idx + LW'(1);
                  rem <= rem - LW'(1);
                  if (rem == LW'(1)) state <= IDLE;
               end
            end
         endcase
      end
   end

   assign flagwrite = bus.FlagW & {2{condexd}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags   <= '0;
         condexd <= 1'b0;
      end else begin
         if (bus.DecodeEn) condexd <= opener ? 1'b1 : condex;
         if (flagwrite[1]) flags[3:2] <= bus.ALUFlags[3:2];
         if (flagwrite[0]) flags[1:0] <= bus.ALUFlags[1:0];
      end
   end

   assign bus.RegWrite = bus.RegW & condexd & ~bus.NoWrite;
   assign bus.MemWrite = bus.MemW & condexd;
   assign bus.PCWrite  = (bus.PCS & condexd) | bus.NextPC;
   assign bus.CondExD  = condexd;
   assign bus.Flags    = flags;
   assign bus.InBlock  = (state == BLOCK);

endmodule

// File: tb/tb_condlogic_mc.sv
// Directed self-checking bench for condlogic_mc.
// Drives on negedge / settles, checks #1 after posedge.
module tb_condlogic_mc;
   import condlogic_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   condlogic_if #(.MAXBLK(4)) bus ();

   condlogic_mc #(.MAXBLK(4), .IT_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic decode(input logic [3:0] c);
      @(negedge clk);
      bus.Cond     = c;
      bus.DecodeEn = 1'b1;
      @(posedge clk);
      #1;
      bus.DecodeEn = 1'b0;
      bus.ItStart  = 1'b0;
   endtask

   task automatic open_it(input logic [3:0] ic, input logic [3:0] m,
                          input logic [2:0] len);
      @(negedge clk);
      bus.ItStart = 1'b1;
      bus.ItCond  = ic;
      bus.ItMask  = m;
      bus.ItLen   = len;
      decode(NV);
   endtask

   task automatic flag_tick(input logic [1:0] fw, input logic [3:0] af);
      @(negedge clk);
      bus.FlagW    = fw;
      bus.ALUFlags = af;
      @(posedge clk);
      #1;
      bus.FlagW = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      bus.Cond = AL;     bus.ALUFlags = '0; bus.FlagW = '0;
      bus.PCS = 1'b0;    bus.NextPC = 1'b1; bus.RegW = 1'b1;
      bus.MemW = 1'b1;   bus.NoWrite = 1'b0; bus.DecodeEn = 1'b0;
      bus.ItStart = 1'b0; bus.ItCond = '0; bus.ItMask = '0;
      bus.ItLen = '0;
      #12;
      chk("rst_flags", 8'(bus.Flags), 8'h0);
      chk("rst_cexd", 8'(bus.CondExD), 8'h0);
      chk("rst_inblk", 8'(bus.InBlock), 8'h0);
      chk("rst_regw", 8'(bus.RegWrite), 8'h0);
      chk("rst_memw", 8'(bus.MemWrite), 8'h0);
      chk("rst_pcw", 8'(bus.PCWrite), 8'h1);
      @(negedge clk);
      reset = 1'b0;
      bus.NextPC = 1'b0;
      bus.MemW = 1'b0;

      decode(AL);
      chk("al_cexd", 8'(bus.CondExD), 8'h1);
      flag_tick(2'b10, 4'b0100);
      chk("flags_0100", 8'(bus.Flags), 8'h4);

      decode(EQ);
      chk("eq_cexd", 8'(bus.CondExD), 8'h1);
      chk("eq_regw", 8'(bus.RegWrite), 8'h1);
      bus.NoWrite = 1'b1;
      #1;
      chk("nowrite", 8'(bus.RegWrite), 8'h0);
      bus.NoWrite = 1'b0;
      decode(NE);
      chk("ne_cexd", 8'(bus.CondExD), 8'h0);
      chk("ne_regw", 8'(bus.RegWrite), 8'h0);

      bus.NextPC = 1'b1; bus.PCS = 1'b0; bus.MemW = 1'b1;
      #1;
      chk("nextpc_pcw", 8'(bus.PCWrite), 8'h1);
      chk("memw_gated", 8'(bus.MemWrite), 8'h0);
      bus.NextPC = 1'b0; bus.PCS = 1'b1;
      #1;
      chk("pcs_gated", 8'(bus.PCWrite), 8'h0);
      bus.PCS = 1'b0; bus.MemW = 1'b0;
      flag_tick(2'b11, 4'b1111);
      chk("flags_no_cexd", 8'(bus.Flags), 8'h4);

      decode(AL);
      flag_tick(2'b10, 4'b1011);
      chk("flags_nz", 8'(bus.Flags), 8'h8);
      flag_tick(2'b01, 4'b1011);
      chk("flags_cv", 8'(bus.Flags), 8'hB);
      decode(GE);
      chk("ge_cexd", 8'(bus.CondExD), 8'h1);
      decode(HI);
      chk("hi_cexd", 8'(bus.CondExD), 8'h1);
      decode(GE);
      flag_tick(2'b10, 4'b0100);
      chk("flags_0111", 8'(bus.Flags), 8'h7);

      open_it(EQ, 4'b0101, 3'd4);
      chk("it_open_cexd", 8'(bus.CondExD), 8'h1);
      chk("it_open_inblk", 8'(bus.InBlock), 8'h1);
      decode(NE);
      chk("it_s0", 8'(bus.CondExD), 8'h1);
      chk("it_s0_blk", 8'(bus.InBlock), 8'h1);
      @(negedge clk);
      bus.ItStart = 1'b1;
      decode(AL);
      chk("it_s1", 8'(bus.CondExD), 8'h0);
      chk("it_s1_blk", 8'(bus.InBlock), 8'h1);
      decode(NE);
      chk("it_s2", 8'(bus.CondExD), 8'h1);
      chk("it_s2_blk", 8'(bus.InBlock), 8'h1);
      decode(AL);
      chk("it_s3", 8'(bus.CondExD), 8'h0);
      chk("it_s3_blk", 8'(bus.InBlock), 8'h0);

      open_it(AL, 4'b0000, 3'd7);
      for (int i = 0; i < 4; i++) begin
         decode(NV);
         chk($sformatf("clamp_s%0d", i), 8'(bus.CondExD), 8'h1);
         chk($sformatf("clamp_b%0d", i), 8'(bus.InBlock),
             (i < 3) ? 8'h1 : 8'h0);
      end
      decode(NV);
      chk("clamp_after", 8'(bus.CondExD), 8'h0);

      open_it(EQ, 4'b1111, 3'd0);
      chk("len0_blk", 8'(bus.InBlock), 8'h0);
      decode(NE);
      chk("len0_cond", 8'(bus.CondExD), 8'h0);
      chk("len0_blk2", 8'(bus.InBlock), 8'h0);

      open_it(EQ, 4'b1111, 3'd3);
      decode(NV);
      chk("fwd_s0", 8'(bus.CondExD), 8'h1);
      flag_tick(2'b10, 4'b0000);
      chk("fwd_flags", 8'(bus.Flags), 8'h3);
      decode(NV);
      chk("fwd_s1", 8'(bus.CondExD), 8'h0);
      decode(NV);
      chk("fwd_end", 8'(bus.InBlock), 8'h0);

      open_it(NE, 4'b1111, 3'd4);
      decode(EQ);
      decode(EQ);
      chk("mid_s1", 8'(bus.CondExD), 8'h1);
      chk("mid_blk", 8'(bus.InBlock), 8'h1);
      bus.NextPC = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_blk", 8'(bus.InBlock), 8'h0);
      chk("mid_rst_flags", 8'(bus.Flags), 8'h0);
      chk("mid_rst_cexd", 8'(bus.CondExD), 8'h0);
      chk("mid_rst_pcw", 8'(bus.PCWrite), 8'h1);
      @(negedge clk);
      reset = 1'b0;
      bus.NextPC = 1'b0;
      decode(EQ);
      chk("post_rst_eq", 8'(bus.CondExD), 8'h0);
      decode(NE);
      chk("post_rst_ne", 8'(bus.CondExD), 8'h1);
      chk("post_rst_blk", 8'(bus.InBlock), 8'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/condlogic_mc.md
CONDLOGIC_MC -- requirements
Module: condlogic_mc

Interface
REQ-001 Parameter MAXBLK, default 4, SHALL set the maximum number of instructions in one predicate block (legal 1..8).
REQ-002 Parameter IT_EN, default 1, SHALL enable predicate-block support; when 0, ItStart SHALL be ignored and the block SHALL stay in IDLE.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 Cond  in  4  condition field of the instruction being decoded.
REQ-006 ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-007 FlagW  in  2  [1] updates N,Z; [0] updates C,V.
REQ-008 PCS, NextPC, RegW, MemW, NoWrite  in  1 each  decoder/FSM write requests.
REQ-009 DecodeEn  in  1  high for exactly the decode cycle of each instruction.
REQ-010 ItStart  in  1  decoded instruction opens a predicate block.
REQ-011 ItCond  in  4  base condition of the block.
REQ-012 ItMask  in  MAXBLK  bit i=1: slot i uses ItCond; 0: uses inverse.
REQ-013 ItLen  in  $clog2(MAXBLK+1)  number of slots in the block.
REQ-014 PCWrite, RegWrite, MemWrite  out  1 each  qualified write enables.
REQ-015 CondExD  out  1  registered condition result of the current instruction.
REQ-016 Flags  out  4  architectural {N,Z,C,V}.
REQ-017 InBlock  out  1  high while predicate slots remain.

Function
REQ-018 Effective condition SHALL be Cond in IDLE, and in BLOCK ItCond (mask bit 1) or ItCond with bit 0 inverted (mask bit 0); ItCond=AL (1110) SHALL stay AL when inverted.
REQ-019 CondEx SHALL be evaluated combinationally from effective condition and current Flags using standard ARM semantics; code 1111 SHALL yield 0.
REQ-020 On a clk edge with DecodeEn=1, CondExD SHALL load CondEx; an instruction with ItStart=1 SHALL load CondExD=1 regardless of Cond.
REQ-021 FlagWrite SHALL equal FlagW & {2{CondExD}}; each enabled group SHALL load from ALUFlags on the clk edge.
REQ-022 RegWrite = RegW & CondExD & ~NoWrite; MemWrite = MemW & CondExD; PCWrite = (PCS & CondExD) | NextPC; all combinational, zero latency.
REQ-023 FSM states SHALL be IDLE and BLOCK with counters rem (remaining) and idx (slot index).
REQ-024 IDLE->BLOCK SHALL occur when DecodeEn & ItStart & IT_EN & ItLen!=0; rem<=min(ItLen,MAXBLK), idx<=0, mask and ItCond latched.
REQ-025 In BLOCK each DecodeEn SHALL consume one slot: idx+1, rem-1; when rem reaches 0 the FSM SHALL return to IDLE on that edge.
REQ-026 ItStart while in BLOCK SHALL be ignored as a block opener; the instruction SHALL consume a slot and be predicated normally.
REQ-027 ItLen=0 SHALL leave the FSM in IDLE; ItLen>MAXBLK SHALL clamp to MAXBLK.
REQ-028 Flags written by a predicated slot SHALL affect the condition of the next slot (no stale flag use).
REQ-029 InBlock SHALL equal (state==BLOCK).

Reset
REQ-030 reset SHALL asynchronously clear Flags=0000, CondExD=0, state=IDLE, rem=0, idx=0, latched mask/cond=0.
REQ-031 During/after reset RegWrite=MemWrite=0 and PCWrite=NextPC; reset mid-block SHALL abandon the block.

Structure
REQ-032 Shared package condlogic_pkg SHALL hold condition-code constants (EQ..AL, NV), flag bit indices and the FSM state type.
REQ-033 Condition evaluation SHALL be one sub-module condcheck (Cond, Flags -> CondEx), instantiated once.

Verification
REQ-034 Flags=0100, Cond=EQ, RegW=1, DecodeEn pulse -> CondExD=1, RegWrite=1; Cond=NE -> RegWrite=0.
REQ-035 ALUFlags=1011, FlagW=10, CondExD=1 -> Flags=1000 next edge; FlagW=01 -> C,V only.
REQ-036 ItStart, ItCond=EQ, ItMask=0101, ItLen=4, Z=1 -> slots CondExD 1,0,1,0; InBlock low after 4th DecodeEn.
REQ-037 ItLen=7 with MAXBLK=4 -> exactly 4 slots; ItLen=0 -> InBlock stays 0.
REQ-038 reset asserted after 2nd slot -> InBlock=0, Flags=0000 immediately, next instruction uses Cond.
REQ-039 NextPC=1, PCS=0, CondExD=0 -> PCWrite=1; MemW=1, CondExD=0 -> MemWrite=0.
